// File: rtl/ram_param.sv
// Simple dual-port RAM with byte-lane writes, registered read-first reads and a
// full-memory clear sweep that runs after reset and on request.
module ram_param #(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 4,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_valid,
    output logic                busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned LANES = DATA_W / 8;

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   clr_ptr_q;
    logic                busy_q;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic accept;
    logic wr_fire;
    logic rd_fire;
    logic sweep_we;

    // A clear request in IDLE takes priority over any access in the same cycle.
    assign accept   = (state_q == StIdle) && !clear;
    assign wr_fire  = accept && wr_en;
    assign rd_fire  = accept && rd_en;
    assign sweep_we = rst && (state_q == StClear);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StClear;
            clr_ptr_q  <= '0;
            busy_q     <= 1'b1;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= mem[rd_addr];
            end
            unique case (state_q)
                StIdle: begin
                    if (clear) begin
                        state_q   <= StClear;
                        clr_ptr_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                StClear: begin
                    clr_ptr_q <= clr_ptr_q + ADDR_W'(1);
                    if (&clr_ptr_q) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Storage is never reset; the sweep initialises it. Reads above see the
    // pre-write word because both blocks update on the same edge.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[clr_ptr_q] <= INIT_VAL;
        end else if (wr_fire) begin
            for (int i = 0; i < LANES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;

endmodule
